// File: rtl/tx_arb_pkg.sv
// Shared types and default widths for the serial-TX arbiter family.
package tx_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        START = 2'd2,
        WAIT  = 2'd3
    } arb_state_t;

    localparam int DATA_W_DEF = 9;
    localparam int DVSR_W_DEF = 3;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr_i, wrapping at N.
module rr_pick #(
    parameter int N     = 4,
    parameter int PTR_W = $clog2(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [PTR_W-1:0] idx_o,
    output logic             valid_o
);

    always_comb begin : pick
        logic [PTR_W:0]   sum;
        logic [PTR_W-1:0] cand;
        logic             found;
        idx_o   = '0;
        valid_o = |req_i;
        found   = 1'b0;
        sum     = '0;
        cand    = '0;
        for (int k = 0; k < N; k++) begin
            // One spare bit on the sum so ptr+k never overflows before the wrap.
            sum = {1'b0, ptr_i} + (PTR_W+1)'(k);
            if (sum >= (PTR_W+1)'(N)) begin
                sum = sum - (PTR_W+1)'(N);
            end
            cand = sum[PTR_W-1:0];
            if (!found && req_i[cand]) begin
                found = 1'b1;
                idx_o = cand;
            end
        end
    end

endmodule

// File: rtl/tx_serial_arbiter.sv
// Round-robin scheduler sharing one serial transmitter between N_REQ clients,
// with a watchdog that aborts a frame whose done pulse never arrives.
module tx_serial_arbiter
    import tx_arb_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int DVSR_W  = DVSR_W_DEF,
    parameter int TIMEOUT = 4096
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [N_REQ-1:0]           req_i,
    input  logic [N_REQ*DATA_W-1:0]    data_i,
    input  logic [N_REQ*DVSR_W-1:0]    dvsr_i,
    output logic [N_REQ-1:0]           ack_o,
    output logic                       tx_start_o,
    output logic [DATA_W-1:0]          tx_data_o,
    output logic [DVSR_W-1:0]          tx_dvsr_o,
    input  logic                       tx_done_i,
    output logic                       busy_o,
    output logic [$clog2(N_REQ)-1:0]   owner_o,
    output logic                       err_o
);

    localparam int PTR_W = $clog2(N_REQ);
    localparam int WD_W  = $clog2(TIMEOUT);

    arb_state_t        state_q, state_d;
    logic [PTR_W-1:0]  winner_q, winner_d;
    logic [PTR_W-1:0]  rr_q, rr_d;
    logic [PTR_W-1:0]  owner_q, owner_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DVSR_W-1:0] dvsr_q, dvsr_d;

    logic [PTR_W-1:0]  pick_idx;
    logic              pick_valid;
    logic [PTR_W-1:0]  rr_inc;
    logic              timeout_hit;

    rr_pick #(
        .N     (N_REQ),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .req_i   (req_i),
        .ptr_i   (rr_q),
        .idx_o   (pick_idx),
        .valid_o (pick_valid)
    );

    assign rr_inc      = (winner_q == PTR_W'(N_REQ - 1)) ? '0 : winner_q + 1'b1;
    assign timeout_hit = (wd_q == WD_W'(TIMEOUT - 1));

    always_comb begin
        state_d  = state_q;
        winner_d = winner_q;
        rr_d     = rr_q;
        owner_d  = owner_q;
        wd_d     = wd_q;
        data_d   = data_q;
        dvsr_d   = dvsr_q;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    winner_d = pick_idx;
                    state_d  = GRANT;
                end
            end
            GRANT: begin
                data_d  = data_i[winner_q*DATA_W +: DATA_W];
                dvsr_d  = dvsr_i[winner_q*DVSR_W +: DVSR_W];
                owner_d = winner_q;
                state_d = START;
            end
            START: begin
                wd_d    = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // A done pulse on the last watchdog cycle still counts as success.
                if (tx_done_i || timeout_hit) begin
                    rr_d    = rr_inc;
                    state_d = IDLE;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= IDLE;
            winner_q <= '0;
            rr_q     <= '0;
            owner_q  <= '0;
            wd_q     <= '0;
            data_q   <= '0;
            dvsr_q   <= '0;
        end else begin
            state_q  <= state_d;
            winner_q <= winner_d;
            rr_q     <= rr_d;
            owner_q  <= owner_d;
            wd_q     <= wd_d;
            data_q   <= data_d;
            dvsr_q   <= dvsr_d;
        end
    end

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_ack
        assign ack_o[gi] = (state_q == GRANT) && (winner_q == PTR_W'(gi));
    end

    assign tx_start_o = (state_q == START);
    assign busy_o     = (state_q != IDLE);
    assign err_o      = (state_q == WAIT) && !tx_done_i && timeout_hit;
    assign tx_data_o  = data_q;
    assign tx_dvsr_o  = dvsr_q;
    assign owner_o    = owner_q;

endmodule
